// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state encoding and store/alignment helpers
// for the memory-stage load/store engine (mem_access_unit).
package mem_pkg;

   // RV64 load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // RV64 store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   // Access size as carried in funct3[1:0]
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Unit state; exposed as the 'state' signal inside mem_access_unit
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   // Low address bits that must be zero for an access of this size
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] m;
      m = 3'b000;
      case (size)
         SZ_B:    m = 3'b000;
         SZ_H:    m = 3'b001;
         SZ_W:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   // Byte strobes for a store of this size at byte lane 'lane'
   function automatic logic [7:0] store_strb(input logic [1:0] size,
                                             input logic [2:0] lane);
      logic [7:0] base;
      base = 8'h00;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return (size == SZ_D) ? 8'hFF : (base << lane);
   endfunction

   // Store data replicated across all lanes so any strobe pattern picks it up
   function automatic logic [63:0] store_lanes(input logic [1:0]  size,
                                               input logic [63:0] data);
      logic [63:0] d;
      d = 64'd0;
      case (size)
         SZ_B:    d = {8{data[7:0]}};
         SZ_H:    d = {4{data[15:0]}};
         SZ_W:    d = {2{data[31:0]}};
         default: d = data;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: aligns the addressed bytes of a 64-bit read beat down to
// bit 0 and sign/zero-extends them according to the load funct3.
module load_extend
   import mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  lane,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] shifted;

   // Lane shift followed by width/sign selection; funct3 111 is not a load
   always_comb begin
      shifted = rdata >> {lane, 3'b000};
      result  = 64'd0;
      case (funct3)
         F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
         F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
         F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
         F3_LD:   result = shifted;
         F3_LBU:  result = {56'd0, shifted[7:0]};
         F3_LHU:  result = {48'd0, shifted[15:0]};
         F3_LWU:  result = {32'd0, shifted[31:0]};
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine. Issues one request per
// regM memory op on the data bus and returns the extended load value.
//
// Bus handshake: dbus_o_req and all dbus_o_* fields are held stable from
// the first REQ cycle until the cycle dbus_i_ready is high (acceptance).
// dbus_i_rvalid is honoured only in the acceptance cycle or later in RESP;
// at any other time it is ignored. Exactly one rvalid ends an access.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to bound the RESP wait to
// TIMEOUT_CYCLES cycles, after which a bus error is reported in DONE.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regM_i_valid,
   input  logic        regM_i_mem_ren,
   input  logic        regM_i_mem_wen,
   input  logic [2:0]  regM_i_funct3,
   input  logic [63:0] regM_i_alu_result,
   input  logic [63:0] regM_i_store_data,
   output logic        dbus_o_req,
   output logic        dbus_o_we,
   output logic [63:0] dbus_o_addr,
   output logic [63:0] dbus_o_wdata,
   output logic [7:0]  dbus_o_wstrb,
   input  logic        dbus_i_ready,
   input  logic        dbus_i_rvalid,
   input  logic [63:0] dbus_i_rdata,
   output logic [63:0] memory_o_memdata,
   output logic        memory_o_stall,
   output logic        memory_o_misalign,
   output logic        memory_o_bus_err
);

   mem_state_e  state;

   logic [63:0] addr_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [63:0] wdata_q;
   logic [7:0]  wstrb_q;
   logic        req_q;
   logic [63:0] memdata_q;
   logic        bus_err_q;

   logic        op;
   logic [1:0]  size;
   logic        misaligned;
   logic        issue;
   logic        timeout_hit;
   logic [63:0] ext_data;
   logic [63:0] capture_data;

   // Decode of the op currently presented by regM
   always_comb begin
      op         = regM_i_valid & (regM_i_mem_ren | regM_i_mem_wen);
      size       = regM_i_funct3[1:0];
      misaligned = |(regM_i_alu_result[2:0] & align_mask(size));
      issue      = (state == IDLE) & op & ~misaligned;
   end

   load_extend u_load_extend (
      .rdata  (dbus_i_rdata),
      .lane   (addr_q[2:0]),
      .funct3 (funct3_q),
      .result (ext_data)
   );

   // Stores complete with a write ack, which carries no load value
   assign capture_data = we_q ? 64'd0 : ext_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [CW-1:0] tmo_cnt;

   // Last permitted RESP cycle with no response in sight
   assign timeout_hit = (state == RESP) & ~dbus_i_rvalid &
                        (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] timeout_cycles_unused;
   assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
   assign timeout_hit = 1'b0;
`endif

   // Access FSM: latches the request, tracks the handshake, captures data
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= 64'd0;
         we_q      <= 1'b0;
         funct3_q  <= 3'd0;
         wdata_q   <= 64'd0;
         wstrb_q   <= 8'd0;
         req_q     <= 1'b0;
         memdata_q <= 64'd0;
         bus_err_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         bus_err_q <= 1'b0;
         case (state)
            IDLE: begin
               memdata_q <= 64'd0;
               if (issue) begin
                  addr_q   <= regM_i_alu_result;
                  we_q     <= regM_i_mem_wen;
                  funct3_q <= regM_i_funct3;
                  wdata_q  <= regM_i_mem_wen ? store_lanes(size, regM_i_store_data) : 64'd0;
                  wstrb_q  <= regM_i_mem_wen ? store_strb(size, regM_i_alu_result[2:0]) : 8'd0;
                  req_q    <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (dbus_i_ready) begin
                  req_q <= 1'b0;
                  if (dbus_i_rvalid) begin
                     memdata_q <= capture_data;
                     state     <= DONE;
                  end else begin
                     state <= RESP;
`ifdef MEM_ACCESS_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end
               end
            end
            RESP: begin
               if (dbus_i_rvalid) begin
                  memdata_q <= capture_data;
                  state     <= DONE;
               end else if (timeout_hit) begin
                  memdata_q <= 64'd0;
                  bus_err_q <= 1'b1;
                  state     <= DONE;
               end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end
            DONE: begin
               // regM still shows the finished op here; it is not re-issued
               memdata_q <= 64'd0;
               state     <= IDLE;
            end
            default: begin
               req_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Bus fields come straight from the latched request
   assign dbus_o_req   = req_q;
   assign dbus_o_we    = we_q;
   assign dbus_o_addr  = {addr_q[63:3], 3'b000};
   assign dbus_o_wdata = wdata_q;
   assign dbus_o_wstrb = wstrb_q;

   // Pipeline-facing status; stall rises in the issue cycle itself
   assign memory_o_memdata  = memdata_q;
   assign memory_o_bus_err  = bus_err_q;
   assign memory_o_stall    = issue | (state == REQ) | (state == RESP);
   assign memory_o_misalign = (state == IDLE) & op & misaligned;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine of the 64-bit in-order pipeline.
- Takes the decoded memory op and address from regM.
- Runs a req/ready + rvalid handshake on the data bus.
- Produces the sign/zero-extended load value (memory_o_memdata) that the W-stage register captures.
- Raises memory_o_stall, which holds regM and bubbles regW, while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in RESP before a bus error is forced. Used only with MEM_ACCESS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- regM_i_valid  in  1  regM holds a real instruction (0 = bubble)
- regM_i_mem_ren  in  1  load
- regM_i_mem_wen  in  1  store (never both with mem_ren)
- regM_i_funct3  in  3  access size/sign (RV64 load/store funct3)
- regM_i_alu_result  in  64  effective byte address
- regM_i_store_data  in  64  store source (rs2)
- dbus_o_req  out  1  request valid
- dbus_o_we  out  1  1 = write
- dbus_o_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0})
- dbus_o_wdata  out  64  lane-replicated store data
- dbus_o_wstrb  out  8  byte strobes (0 for loads)
- dbus_i_ready  in  1  request accepted this cycle
- dbus_i_rvalid  in  1  response (read data or write ack)
- dbus_i_rdata  in  64  read data
- memory_o_memdata  out  64  extended load result
- memory_o_stall  out  1  hold regM / bubble regW
- memory_o_misalign  out  1  misaligned access detected (1-cycle pulse)
- memory_o_bus_err  out  1  timeout error (1-cycle pulse, in DONE)

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset → IDLE. Reset values: all outputs 0, latched request registers 0.
- Op = regM_i_valid & (mem_ren | mem_wen). Misaligned when addr is not a multiple of the access size: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- IDLE, op and aligned: latch addr, we, funct3, wdata, wstrb → REQ. memory_o_stall=1 combinationally in this cycle.
- IDLE, op and misaligned: no bus activity, stall=0, misalign=1 this cycle, memdata=0; stay in IDLE.
- IDLE, no op: stall=0, memdata=0.
- REQ: req=1 with all bus fields from latched registers, stable until ready. stall=1.
  - ready & rvalid in the same cycle → DONE, capture data.
  - ready only → RESP.
- RESP: req=0, stall=1. rvalid → DONE, capture data.
- DONE: stall=0. memdata holds the captured extended value (0 for stores). Unconditionally → IDLE next cycle. The op still visible on regM in DONE is not re-issued.
- rvalid seen in IDLE or REQ-without-ready is ignored.
- Minimum load-to-data: op seen in cycle 0, zero-wait bus → data presented in cycle 2; stall high in cycles 0–1.
- Store lanes, with lane = addr[2:0]:
  - SB: data[7:0] ×8, wstrb = 8'h01<<lane
  - SH: data[15:0] ×4, wstrb = 8'h03<<lane
  - SW: data[31:0] ×2, wstrb = 8'h0F<<lane
  - SD: data, wstrb = 8'hFF
- Load: shift rdata right by lane×8, then extend by funct3:
  - 000 LB sign-8, 001 LH sign-16, 010 LW sign-32, 011 LD
  - 100 LBU, 101 LHU, 110 LWU zero-extend
  - 111 → value 0
- Reset mid-operation: rst in any state → IDLE next edge; req drops; any late response is ignored.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined:
  - Counter cleared on entry to RESP, incremented each RESP cycle.
  - When it reaches TIMEOUT_CYCLES without rvalid → DONE with memdata=0 and bus_err=1 for that DONE cycle.
  - A later stale rvalid is ignored.
- Undefined: no counter; bus_err tied 0; RESP waits indefinitely.

Decomposition:
- Package mem_pkg:
  - funct3 constants (LB..LWU, SB..SD)
  - state enum (IDLE/REQ/RESP/DONE)
  - size decode helper constants
- Sub-module load_extend: combinational lane shift plus sign/zero extension (rdata, lane, funct3 → 64-bit result), reused by the unit's DONE capture path.

Test Plan:
- LD at 0x1000, rdata=0x1122334455667788, ready&rvalid in REQ → stall cycles 0–1; cycle 2 memdata=0x1122334455667788, stall=0.
- LB at 0x1003, rdata byte3=0x80 → memdata=0xFFFFFFFFFFFFFF80. LBU at the same address → memdata=0x80.
- SH at 0x2006, data=0xABCD → dbus_o_addr=0x2000, wstrb=0xC0, wdata=0xABCDABCDABCDABCD, we=1.
- LW at 0x3002 → misalign=1 for one cycle, no req, stall=0.
- LD with ready held low 3 cycles, then rvalid 2 cycles after accept → req stable for 4 cycles, then stall released exactly in DONE.
- rst asserted in RESP, then rvalid arrives → IDLE, no DONE, memdata=0. With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no rvalid → bus_err pulse after 4 RESP cycles.
